// File: rtl/visualizer_frame_sequencer_pkg.sv
// Shared types for the visualizer frame sequencer.
// Defines FSM states, the rgb pixel type and the LED counter width helper.
package vis_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STREAM
  } seq_state_e;

  typedef logic [23:0] rgb_t;

  // Counter wide enough to hold 0..leds inclusive
  function automatic int cnt_w(input int leds);
    return $clog2(leds + 1);
  endfunction

endpackage

// File: rtl/visualizer_frame_sequencer_led_run_expander.sv
// led_run_expander: expands per-bin (rgb, count) runs into an LEDS-long pixel
// stream. Ports: i_load/i_active control, i_counts/i_rgb, px_* stream, o_end.
module led_run_expander
  import vis_seq_pkg::*;
#(
  parameter int LEDS    = 50,
  parameter int BIN_QTY = 12,
  localparam int CW     = $clog2(LEDS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_load,
  input  logic                          i_active,
  input  logic [BIN_QTY-1:0][CW-1:0]    i_counts,
  input  rgb_t [BIN_QTY-1:0]            i_rgb,
  output logic                          px_valid,
  input  logic                          px_ready,
  output rgb_t                          px_rgb,
  output logic                          px_last,
  output logic                          o_end
);

  localparam int RW = cnt_w(LEDS);
  localparam int BW = $clog2(BIN_QTY);
  localparam logic [RW-1:0] PLAST = RW'(LEDS - 1);
  localparam logic [BW-1:0] BLAST = BW'(BIN_QTY - 1);

  logic [BW-1:0] r_b;
  logic [RW-1:0] r_r;
  logic [RW-1:0] r_p;
  logic          w_bubble;
  logic          w_pad;
  logic          w_hs;

  // An empty bin before the last one costs one cycle to fetch the next count
  assign w_bubble = (r_r == '0) && (r_b != BLAST);
  assign w_pad    = (r_r == '0) && (r_b == BLAST);
  assign px_valid = i_active && !w_bubble;
  assign px_rgb   = (i_active && !w_pad) ? i_rgb[r_b] : '0;
  assign px_last  = i_active && (r_p == PLAST);
  assign w_hs     = px_valid && px_ready;
  assign o_end    = w_hs && px_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_b <= '0;
      r_r <= '0;
      r_p <= '0;
    end else if (i_load) begin
      r_b <= '0;
      r_r <= RW'(i_counts[0]);
      r_p <= '0;
    end else if (i_active) begin
      if (w_bubble) begin
        r_b <= r_b + BW'(1);
        r_r <= RW'(i_counts[r_b + BW'(1)]);
      end else if (w_hs) begin
        if (r_p != PLAST) r_p <= r_p + RW'(1);
        if (r_r != '0)    r_r <= r_r - RW'(1);
      end
    end
  end

endmodule

// File: rtl/visualizer_frame_sequencer.sv
// Frame sequencer: accepts a note frame, runs the visualizer, streams LEDs.
// Optional RUN watchdog enabled by defining VIS_SEQ_TIMEOUT_EN.
module visualizer_frame_sequencer
  import vis_seq_pkg::*;
#(
  parameter int W           = 6,
  parameter int D           = 10,
  parameter int LEDS        = 50,
  parameter int BIN_QTY     = 12,
  parameter int START_HOLD  = 2,
  parameter int TIMEOUT_CYC = 4096,
  localparam int NW         = W + D,
  localparam int CW         = $clog2(LEDS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BIN_QTY-1:0][NW-1:0]  in_amplitudes,
  input  logic [BIN_QTY-1:0][NW-1:0]  in_positions,
  output logic [BIN_QTY-1:0][NW-1:0]  vis_amplitudes,
  output logic [BIN_QTY-1:0][NW-1:0]  vis_positions,
  output logic                        vis_start,
  input  logic                        vis_done,
  input  rgb_t [BIN_QTY-1:0]          vis_rgb,
  input  logic [BIN_QTY-1:0][CW-1:0]  vis_led_counts,
  output logic                        px_valid,
  input  logic                        px_ready,
  output rgb_t                        px_rgb,
  output logic                        px_last,
  output logic                        frame_done,
  output logic                        err_timeout
);

  localparam int HW = $clog2(START_HOLD + 2);
  localparam logic [HW-1:0] HMAX = HW'(START_HOLD);

  seq_state_e                  r_state;
  logic [HW-1:0]               r_hold;
  rgb_t [BIN_QTY-1:0]          r_rgb;
  logic [BIN_QTY-1:0][CW-1:0]  r_cnt;
  logic                        w_qual;
  logic                        w_end;
  logic [BIN_QTY-1:0][CW-1:0]  w_cnt;

  assign in_ready = (r_state == IDLE);
  assign w_qual   = (r_state == RUN) && vis_done && (r_hold == HMAX);
  // Expander loads bin 0 on the same edge the snapshot is taken
  assign w_cnt    = w_qual ? vis_led_counts : r_cnt;

`ifdef VIS_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] r_tcnt;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_hold         <= '0;
      r_rgb          <= '0;
      r_cnt          <= '0;
      vis_amplitudes <= '0;
      vis_positions  <= '0;
      vis_start      <= 1'b0;
      frame_done     <= 1'b0;
`ifdef VIS_SEQ_TIMEOUT_EN
      r_tcnt         <= '0;
      err_timeout    <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
`ifdef VIS_SEQ_TIMEOUT_EN
      err_timeout <= 1'b0;
`endif
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            vis_amplitudes <= in_amplitudes;
            vis_positions  <= in_positions;
            vis_start      <= 1'b1;
            r_hold         <= '0;
            r_state        <= RUN;
`ifdef VIS_SEQ_TIMEOUT_EN
            r_tcnt         <= '0;
`endif
          end
        end
        RUN: begin
          if (w_qual) begin
            r_rgb     <= vis_rgb;
            r_cnt     <= vis_led_counts;
            vis_start <= 1'b0;
            r_state   <= STREAM;
          end
`ifdef VIS_SEQ_TIMEOUT_EN
          else if (r_tcnt == TLAST) begin
            vis_start   <= 1'b0;
            err_timeout <= 1'b1;
            r_state     <= IDLE;
          end
`endif
          else begin
            if (r_hold != HMAX) r_hold <= r_hold + HW'(1);
`ifdef VIS_SEQ_TIMEOUT_EN
            r_tcnt <= r_tcnt + TW'(1);
`endif
          end
        end
        STREAM: begin
          if (w_end) begin
            frame_done <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  led_run_expander #(
    .LEDS    (LEDS),
    .BIN_QTY (BIN_QTY)
  ) u_exp (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_qual),
    .i_active (r_state == STREAM),
    .i_counts (w_cnt),
    .i_rgb    (r_rgb),
    .px_valid (px_valid),
    .px_ready (px_ready),
    .px_rgb   (px_rgb),
    .px_last  (px_last),
    .o_end    (w_end)
  );

endmodule

// File: tb/tb_visualizer_frame_sequencer.sv
// Testbench for visualizer_frame_sequencer: table of frames with hand-computed
// pixel runs and bubble counts, plus late-done, stall and mid-stream reset.
module tb_visualizer_frame_sequencer;
  import vis_seq_pkg::*;

  localparam int W  = 6;
  localparam int D  = 10;
  localparam int NW = W + D;
  localparam int LEDS = 50;
  localparam int BQ = 12;
  localparam int CW = $clog2(LEDS);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [BQ-1:0][NW-1:0]  in_amplitudes;
  logic [BQ-1:0][NW-1:0]  in_positions;
  logic [BQ-1:0][NW-1:0]  vis_amplitudes;
  logic [BQ-1:0][NW-1:0]  vis_positions;
  logic                   vis_start;
  logic                   vis_done;
  rgb_t [BQ-1:0]          vis_rgb;
  logic [BQ-1:0][CW-1:0]  vis_led_counts;
  logic                   px_valid;
  logic                   px_ready;
  rgb_t                   px_rgb;
  logic                   px_last;
  logic                   frame_done;
  logic                   err_timeout;

  visualizer_frame_sequencer #(
    .W(W), .D(D), .LEDS(LEDS), .BIN_QTY(BQ),
    .START_HOLD(2), .TIMEOUT_CYC(4096)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_amplitudes  (in_amplitudes),
    .in_positions   (in_positions),
    .vis_amplitudes (vis_amplitudes),
    .vis_positions  (vis_positions),
    .vis_start      (vis_start),
    .vis_done       (vis_done),
    .vis_rgb        (vis_rgb),
    .vis_led_counts (vis_led_counts),
    .px_valid       (px_valid),
    .px_ready       (px_ready),
    .px_rgb         (px_rgb),
    .px_last        (px_last),
    .frame_done     (frame_done),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    cnt[12];
    int    stall;
    int    rrgb[8];
    int    rlen[8];
    int    bub;
  } vec_t;

  vec_t vecs[7];
  int pass_n = 0;
  int tot_n  = 0;

  task automatic chk(input string nm, input logic [255:0] got,
                     input logic [255:0] exp);
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic run_frame(input int vi, input int late,
                           input int exp_vs, input int abort_after);
    int n, bub, vs, idx;
    bit strm, dpend, fin;
    logic pv, pr, pl;
    rgb_t prgb;
    int gr[50];
    int gl[50];
    int er[50];
    logic [BQ-1:0][NW-1:0] ea, ep;
    n = 0; bub = 0; vs = 0;
    strm = 0; dpend = 0; fin = 0;
    pv = 0; pr = 0; pl = 0; prgb = '0;
    for (int i = 0; i < BQ; i++) begin
      ea[i] = NW'(vi * 100 + i);
      ep[i] = NW'(vi * 100 + i + 50);
      vis_led_counts[i] = CW'(vecs[vi].cnt[i]);
      vis_rgb[i] = 24'(i + 1);
    end
    in_amplitudes = ea;
    in_positions  = ep;
    vis_done = (late == 0);
    px_ready = 1'b0;
    @(negedge clk);
    chk({vecs[vi].name, " in_ready idle"}, 256'(in_ready), 256'(1));
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({vecs[vi].name, " vis_amp"}, 256'(vis_amplitudes), 256'(ea));
    chk({vecs[vi].name, " vis_pos"}, 256'(vis_positions), 256'(ep));
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (late > 0 && cyc == late) vis_done = 1'b1;
      if (!strm) begin
        if (vis_start) vs++;
        else strm = 1;
      end
      if (strm) begin
        if (dpend) begin
          chk({vecs[vi].name, " frame_done"}, 256'(frame_done), 256'(1));
          chk({vecs[vi].name, " in_ready done"}, 256'(in_ready), 256'(1));
          chk({vecs[vi].name, " px_valid done"}, 256'(px_valid), 256'(0));
          fin = 1;
        end else begin
          if (pv && !pr)
            chk($sformatf("%s stall hold n%0d", vecs[vi].name, n),
                256'({px_valid, px_last, px_rgb}), 256'({1'b1, pl, prgb}));
          px_ready = (vecs[vi].stall == 0) || (cyc % 3 == 0);
          if (!px_valid) bub++;
          else if (px_ready) begin
            if (n < 50) begin
              gr[n] = int'(px_rgb);
              gl[n] = int'(px_last);
            end
            n++;
            if (n == LEDS) dpend = 1;
            if (n == abort_after) fin = 1;
          end
          pv = px_valid; pr = px_ready; pl = px_last; prgb = px_rgb;
        end
      end
    end
    chk({vecs[vi].name, " frame timeout"}, 256'(fin), 256'(1));
    idx = 0;
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < vecs[vi].rlen[k]; j++) begin
        if (idx < 50) er[idx] = vecs[vi].rrgb[k];
        idx++;
      end
    for (int i = 0; i < n && i < 50; i++)
      chk($sformatf("%s px%0d", vecs[vi].name, i),
          256'({gl[i][0], gr[i][23:0]}),
          256'({(i == LEDS - 1), er[i][23:0]}));
    if (abort_after == 0) begin
      chk({vecs[vi].name, " start cycles"}, 256'(vs), 256'(exp_vs));
      chk({vecs[vi].name, " bubbles"}, 256'(bub), 256'(vecs[vi].bub));
      @(negedge clk);
      chk({vecs[vi].name, " post frame"},
          256'({frame_done, px_valid}), 256'(0));
    end
    vis_done = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL global watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"basic", '{10,10,10,10,10,0,0,0,0,0,0,0}, 0,
                '{1,2,3,4,5,0,0,0}, '{10,10,10,10,10,0,0,0}, 4};
    vecs[1] = '{"pad", '{5,5,5,5,5,5,0,0,0,0,0,0}, 0,
                '{1,2,3,4,5,6,0,0}, '{5,5,5,5,5,5,20,0}, 11};
    vecs[2] = '{"trunc", '{20,20,20,10,0,0,0,0,0,0,0,0}, 0,
                '{1,2,3,0,0,0,0,0}, '{20,20,10,0,0,0,0,0}, 2};
    vecs[3] = '{"skip0", '{0,50,0,0,0,0,0,0,0,0,0,0}, 0,
                '{2,0,0,0,0,0,0,0}, '{50,0,0,0,0,0,0,0}, 1};
    vecs[4] = '{"stall", '{10,10,10,10,10,0,0,0,0,0,0,0}, 1,
                '{1,2,3,4,5,0,0,0}, '{10,10,10,10,10,0,0,0}, 4};
    vecs[5] = '{"allzero", '{0,0,0,0,0,0,0,0,0,0,0,0}, 0,
                '{0,0,0,0,0,0,0,0}, '{50,0,0,0,0,0,0,0}, 11};
    vecs[6] = '{"lastbin", '{0,0,0,0,0,0,0,0,0,0,0,50}, 0,
                '{12,0,0,0,0,0,0,0}, '{50,0,0,0,0,0,0,0}, 11};

    rst = 1'b0;
    in_valid = 1'b0;
    in_amplitudes = '0;
    in_positions = '0;
    vis_done = 1'b0;
    vis_rgb = '0;
    vis_led_counts = '0;
    px_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst in_ready", 256'(in_ready), 256'(1));
    chk("rst vis_start", 256'(vis_start), 256'(0));
    chk("rst px_valid", 256'(px_valid), 256'(0));
    chk("rst px_last", 256'(px_last), 256'(0));
    chk("rst frame_done", 256'(frame_done), 256'(0));
    chk("rst err_timeout", 256'(err_timeout), 256'(0));
    chk("rst vis_amp", 256'(vis_amplitudes), 256'(0));
    rst = 1'b1;

    for (int v = 0; v < 7; v++) run_frame(v, 0, 3, 0);

    // vis_done arrives 12 cycles into RUN: start held until then
    run_frame(0, 12, 13, 0);

    // reset during the stream right after pixel 20 is handed over
    run_frame(0, 0, 3, 21);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst px_valid", 256'(px_valid), 256'(0));
    chk("midrst px_last", 256'(px_last), 256'(0));
    chk("midrst vis_start", 256'(vis_start), 256'(0));
    chk("midrst in_ready", 256'(in_ready), 256'(1));
    chk("midrst frame_done", 256'(frame_done), 256'(0));
    chk("midrst vis_amp", 256'(vis_amplitudes), 256'(0));
    @(negedge clk);
    rst = 1'b1;
    run_frame(1, 0, 3, 0);

`ifdef VIS_SEQ_TIMEOUT_EN
    begin
      bit seen;
      seen = 0;
      vis_done = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 0; c < 5000 && !seen; c++) begin
        @(negedge clk);
        if (err_timeout) seen = 1;
      end
      chk("timeout seen", 256'(seen), 256'(1));
      chk("timeout idle", 256'({in_ready, vis_start, px_valid}),
          256'(3'b100));
    end
`endif

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
